// File: rtl/hazard_scheduler.sv
// Hazard scheduler for a 5-stage RV32 pipeline without forwarding: scoreboards
// in-flight destinations, stalls on RAW hazards and flushes on taken branches.
module hazard_scheduler #(
  parameter bit WB_BYPASS = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             br_taken_mem_i,
  output logic             pc_hold_o,
  output logic             ifid_hold_o,
  output logic             idex_bubble_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             flush_exmem_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    STALL    = 2'b01,
    REDIRECT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state_q, state_d;

  logic       ex_v_q, mem_v_q, wb_v_q;
  logic       ex_v_d, mem_v_d, wb_v_d;
  logic [4:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic [4:0] ex_rd_d, mem_rd_d, wb_rd_d;

  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic rs1_hit, rs2_hit, hit, insert;
  logic stall_inc, flush_inc;
  logic pc_hold, ifid_hold, idex_bubble, flush_all;

  // The WB slot only matters when the register file cannot write-before-read.
  always_comb begin
    rs1_hit = id_use_rs1_i && (id_rs1_i != 5'd0) &&
              ((ex_v_q  && (ex_rd_q  == id_rs1_i)) ||
               (mem_v_q && (mem_rd_q == id_rs1_i)) ||
               (!WB_BYPASS && wb_v_q && (wb_rd_q == id_rs1_i)));
    rs2_hit = id_use_rs2_i && (id_rs2_i != 5'd0) &&
              ((ex_v_q  && (ex_rd_q  == id_rs2_i)) ||
               (mem_v_q && (mem_rd_q == id_rs2_i)) ||
               (!WB_BYPASS && wb_v_q && (wb_rd_q == id_rs2_i)));
    hit     = id_valid_i && (rs1_hit || rs2_hit);
    insert  = id_valid_i && id_regwrite_i && (id_rd_i != 5'd0) &&
              (state_q != REDIRECT);
  end

  always_comb begin
    state_d     = RUN;
    ex_v_d      = insert;
    ex_rd_d     = id_rd_i;
    mem_v_d     = ex_v_q;
    mem_rd_d    = ex_rd_q;
    wb_v_d      = mem_v_q;
    wb_rd_d     = mem_rd_q;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_bubble = 1'b0;
    flush_all   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (br_taken_mem_i) begin
      flush_all = 1'b1;
      flush_inc = 1'b1;
      ex_v_d    = 1'b0;
      mem_v_d   = 1'b0;
      state_d   = REDIRECT;
    end else if (hit && (state_q != REDIRECT)) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
      ex_v_d      = 1'b0;
      state_d     = STALL;
    end
  end

  // Control outputs are forced low while reset is held so nothing leaks out.
  assign pc_hold_o     = rst_n && pc_hold;
  assign ifid_hold_o   = rst_n && ifid_hold;
  assign idex_bubble_o = rst_n && idex_bubble;
  assign flush_ifid_o  = rst_n && flush_all;
  assign flush_idex_o  = rst_n && flush_all;
  assign flush_exmem_o = rst_n && flush_all;
  assign state_o       = state_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      ex_v_q   <= 1'b0;
      mem_v_q  <= 1'b0;
      wb_v_q   <= 1'b0;
      ex_rd_q  <= 5'd0;
      mem_rd_q <= 5'd0;
      wb_rd_q  <= 5'd0;
    end else begin
      state_q  <= state_d;
      ex_v_q   <= ex_v_d;
      mem_v_q  <= mem_v_d;
      wb_v_q   <= wb_v_d;
      ex_rd_q  <= ex_rd_d;
      mem_rd_q <= mem_rd_d;
      wb_rd_q  <= wb_rd_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != CNT_MAX))
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_inc && (flush_cnt_q != CNT_MAX))
        flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Checks three hazard_scheduler configurations (no bypass, WB bypass, 4-bit
// counters) against an abstract scoreboard model driven by shared inputs.
module tb_hazard_scheduler;

  logic       clk, rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, br_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic [5:0]  ctl0, ctl1, ctl2;
  logic [1:0]  st0, st1, st2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  int vectors, miscompares;

  // Model: rd of the instruction occupying EX/MEM/WB (0 = empty), state, counters.
  int m_ex[3], m_mem[3], m_wb[3], m_st[3], m_sc[3], m_fc[3];
  localparam logic [2:0] BYP = 3'b010;

  hazard_scheduler #(.WB_BYPASS(1'b0), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs1_i(id_rs1),
    .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .br_taken_mem_i(br_taken),
    .pc_hold_o(ctl0[5]), .ifid_hold_o(ctl0[4]), .idex_bubble_o(ctl0[3]),
    .flush_ifid_o(ctl0[2]), .flush_idex_o(ctl0[1]), .flush_exmem_o(ctl0[0]),
    .state_o(st0), .stall_cnt_o(sc0), .flush_cnt_o(fc0));

  hazard_scheduler #(.WB_BYPASS(1'b1), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs1_i(id_rs1),
    .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .br_taken_mem_i(br_taken),
    .pc_hold_o(ctl1[5]), .ifid_hold_o(ctl1[4]), .idex_bubble_o(ctl1[3]),
    .flush_ifid_o(ctl1[2]), .flush_idex_o(ctl1[1]), .flush_exmem_o(ctl1[0]),
    .state_o(st1), .stall_cnt_o(sc1), .flush_cnt_o(fc1));

  hazard_scheduler #(.WB_BYPASS(1'b0), .CNT_W(4)) dut2 (
    .clk_i(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_rs1_i(id_rs1),
    .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .br_taken_mem_i(br_taken),
    .pc_hold_o(ctl2[5]), .ifid_hold_o(ctl2[4]), .idex_bubble_o(ctl2[3]),
    .flush_ifid_o(ctl2[2]), .flush_idex_o(ctl2[1]), .flush_exmem_o(ctl2[0]),
    .state_o(st2), .stall_cnt_o(sc2), .flush_cnt_o(fc2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cnt_max(int k);
    return (k == 2) ? 15 : 65535;
  endfunction

  function automatic bit busy(int k, int r);
    return (r != 0) && (m_ex[k] == r || m_mem[k] == r || (!BYP[k] && m_wb[k] == r));
  endfunction

  function automatic bit model_hit(int k);
    return id_valid && ((id_use_rs1 && busy(k, int'(id_rs1))) ||
                        (id_use_rs2 && busy(k, int'(id_rs2))));
  endfunction

  function automatic logic [5:0] model_ctl(int k);
    if (!rst_n)                      return 6'b000000;
    if (br_taken)                    return 6'b000111;
    if (model_hit(k) && m_st[k] != 2) return 6'b111000;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ex[k] = 0; m_mem[k] = 0; m_wb[k] = 0;
      m_st[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      bit h   = model_hit(k);
      int ins = (m_st[k] != 2 && id_valid && id_regwrite) ? int'(id_rd) : 0;
      if (br_taken) begin
        m_wb[k] = m_mem[k]; m_mem[k] = 0; m_ex[k] = 0; m_st[k] = 2;
        if (m_fc[k] < cnt_max(k)) m_fc[k]++;
      end else if (h && m_st[k] != 2) begin
        m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = 0; m_st[k] = 1;
        if (m_sc[k] < cnt_max(k)) m_sc[k]++;
      end else begin
        m_wb[k] = m_mem[k]; m_mem[k] = m_ex[k]; m_ex[k] = ins; m_st[k] = 0;
      end
    end
  endtask

  task automatic expect_val(string tag, logic [15:0] obs, logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    expect_val("ctl0", {10'd0, ctl0}, {10'd0, model_ctl(0)});
    expect_val("ctl1", {10'd0, ctl1}, {10'd0, model_ctl(1)});
    expect_val("ctl2", {10'd0, ctl2}, {10'd0, model_ctl(2)});
    expect_val("state0", {14'd0, st0}, 16'(m_st[0]));
    expect_val("state1", {14'd0, st1}, 16'(m_st[1]));
    expect_val("state2", {14'd0, st2}, 16'(m_st[2]));
    expect_val("stall0", sc0, 16'(m_sc[0]));
    expect_val("stall1", sc1, 16'(m_sc[1]));
    expect_val("stall2", {12'd0, sc2}, 16'(m_sc[2]));
    expect_val("flush0", fc0, 16'(m_fc[0]));
    expect_val("flush1", fc1, 16'(m_fc[1]));
    expect_val("flush2", {12'd0, fc2}, 16'(m_fc[2]));
  endtask

  task automatic apply_stimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic rw, input logic br);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; br_taken = br;
  endtask

  task automatic cycle_begin(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic u1, input logic u2, input logic [4:0] rd,
                             input logic rw, input logic br);
    apply_stimulus(v, rs1, rs2, u1, u2, rd, rw, br);
    #1;
    check_output();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic run_cycle(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic u1, input logic u2, input logic [4:0] rd,
                           input logic rw, input logic br);
    cycle_begin(v, rs1, rs2, u1, u2, rd, rw, br);
    cycle_end();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    model_reset();
    #2;
    check_output();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset arriving in the middle of a stall aborts it immediately
    run_cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    cycle_begin(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    expect_val("stall_before_reset", {10'd0, ctl0}, 16'h0038);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_output();
    expect_val("reset_ctl", {10'd0, ctl0}, 16'h0000);
    expect_val("reset_state", {14'd0, st0}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cycle_begin(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);
    expect_val("after_reset_no_hold", {15'd0, ctl0[5]}, 16'h0000);
    cycle_end();

    // Back-to-back dependency: 3 stalls without bypass, 2 with it
    cycle_begin(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1 rst_n = 1'b1;
    cycle_end();
    run_cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    repeat (4) run_cycle(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
    cycle_begin(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_val("stalls_no_bypass", sc0, 16'd3);
    expect_val("stalls_bypass", sc1, 16'd2);
    cycle_end();

    // x0 is never a hazard
    run_cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    cycle_begin(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    expect_val("x0_no_hold", {15'd0, ctl0[5]}, 16'h0000);
    cycle_end();
    cycle_begin(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_val("x0_stalls_unchanged", sc0, 16'd3);
    cycle_end();

    // Taken branch, then REDIRECT suppresses a hazard on the WB slot
    run_cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
    run_cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle_begin(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    expect_val("branch_flush", {10'd0, ctl0}, 16'h0007);
    cycle_end();
    cycle_begin(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    expect_val("redirect_state", {14'd0, st0}, 16'h0002);
    expect_val("redirect_no_hold", {10'd0, ctl0}, 16'h0000);
    cycle_end();
    cycle_begin(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_val("back_to_run", {14'd0, st0}, 16'h0000);
    expect_val("flush_count", fc0, 16'd1);
    cycle_end();

    // Branch beats a hazard in the same cycle and squashes the producer
    run_cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0);
    cycle_begin(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b1);
    expect_val("branch_over_hazard", {10'd0, ctl0}, 16'h0007);
    cycle_end();
    run_cycle(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    cycle_begin(1'b1, 5'd10, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
    expect_val("squashed_no_hold", {15'd0, ctl0[5]}, 16'h0000);
    expect_val("squash_stalls_same", sc0, 16'd3);
    cycle_end();

    // Enough stalls to saturate the 4-bit counter
    for (int i = 0; i < 7; i++) begin
      run_cycle(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'(i + 12), 1'b1, 1'b0);
      repeat (4) run_cycle(1'b1, 5'(i + 12), 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    end
    cycle_begin(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    expect_val("stall_saturate", {12'd0, sc2}, 16'd15);
    cycle_end();

    // Random traffic over a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      run_cycle(logic'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), logic'($urandom_range(0, 1)),
                logic'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                logic'($urandom_range(0, 1)), logic'($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
